// File: rtl/tm_pkg.sv
// Shared types and defaults for the Turing machine front-panel sequencer.
package tm_pkg;

  localparam int STATE_W_MAX  = 4;
  localparam int STATE_W_DEF  = 4;
  localparam int TAPE_LEN_DEF = 64;

  typedef enum logic [1:0] {
    LOAD_RULE = 2'd0,
    LOAD_TAPE = 2'd1,
    RUN       = 2'd2,
    HALT      = 2'd3
  } phase_t;

  typedef struct packed {
    logic [STATE_W_MAX-1:0] next_state;
    logic                   write_sym;
    logic                   move_right;
  } rule_t;

endpackage

// File: rtl/tm_btn_edge.sv
// Registered rising-edge detector for a level-sensitive front-panel button.
module tm_btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  always_ff @(posedge clock) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/tm_program_sequencer.sv
// Front-panel sequencer: rule entry, tape entry, single-step run and halt.
// Optional free-run stepping in RUN is enabled by defining TM_FREERUN_EN.
module tm_program_sequencer
  import tm_pkg::*;
#(
  parameter int  STATE_W  = STATE_W_DEF,
  parameter int  TAPE_LEN = TAPE_LEN_DEF,
  localparam int TAPE_AW  = $clog2(TAPE_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         input_data,
  input  logic               Next,
  input  logic               Done,
  input  logic               halted,
  output logic               rule_we,
  output logic [STATE_W:0]   rule_addr,
  output logic [STATE_W+1:0] rule_wdata,
  output logic               tape_we,
  output logic [TAPE_AW-1:0] tape_addr,
  output logic               tape_wdata,
  output logic               step,
  output logic [1:0]         phase,
  output logic               Compute_done
);

  logic nx_e, dn_e, nx, dn;

  tm_btn_edge u_next_edge (.clock(clock), .reset(reset), .btn(Next), .rise(nx_e));
  tm_btn_edge u_done_edge (.clock(clock), .reset(reset), .btn(Done), .rise(dn_e));

  // Done takes priority when both buttons rise together.
  assign dn = dn_e;
  assign nx = nx_e & ~dn_e;

  phase_t                 phase_q, phase_d;
  logic [1:0]             fld_q;
  logic [STATE_W_MAX-1:0] ns_q;
  logic                   ws_q;
  logic [STATE_W:0]       rcnt_q;
  logic                   rule_full_q;
  logic [TAPE_AW-1:0]     tcnt_q;
  logic                   rule_we_d, tape_we_d, step_d;
  rule_t                  rule_new;

`ifdef TM_FREERUN_EN
  logic free_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) phase_q <= LOAD_RULE;
    else       phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      LOAD_RULE: if (dn) phase_d = LOAD_TAPE;
      LOAD_TAPE: if (dn) phase_d = RUN;
      RUN:       if (halted) phase_d = HALT;
      default:   phase_d = HALT;
    endcase
  end

  always_comb begin
    rule_new.next_state = ns_q;
    rule_new.write_sym  = ws_q;
    rule_new.move_right = input_data[0];
    rule_we_d = (phase_q == LOAD_RULE) && nx && (fld_q == 2'd2) && !rule_full_q;
    tape_we_d = (phase_q == LOAD_TAPE) && nx;
`ifdef TM_FREERUN_EN
    step_d    = (phase_q == RUN) && !halted && (free_q || nx);
`else
    step_d    = (phase_q == RUN) && !halted && nx;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fld_q       <= '0;
      ns_q        <= '0;
      ws_q        <= 1'b0;
      rcnt_q      <= '0;
      rule_full_q <= 1'b0;
      tcnt_q      <= '0;
      rule_we     <= 1'b0;
      rule_addr   <= '0;
      rule_wdata  <= '0;
      tape_we     <= 1'b0;
      tape_addr   <= '0;
      tape_wdata  <= 1'b0;
      step        <= 1'b0;
`ifdef TM_FREERUN_EN
      free_q      <= 1'b0;
`endif
    end else begin
      rule_we <= rule_we_d;
      tape_we <= tape_we_d;
      step    <= step_d;

      if (phase_q == LOAD_RULE) begin
        if (dn) begin
          fld_q <= '0;
        end else if (nx) begin
          case (fld_q)
            2'd0:    begin ns_q <= STATE_W_MAX'(input_data[STATE_W-1:0]); fld_q <= 2'd1; end
            2'd1:    begin ws_q <= input_data[0]; fld_q <= 2'd2; end
            default: fld_q <= 2'd0;
          endcase
        end
      end

      // Last rule slot is written once, then the counter stays pinned.
      if (rule_we_d) begin
        rule_addr  <= rcnt_q;
        rule_wdata <= {rule_new.next_state[STATE_W-1:0], rule_new.write_sym, rule_new.move_right};
        if (rcnt_q == '1) rule_full_q <= 1'b1;
        else              rcnt_q      <= rcnt_q + 1'b1;
      end

      if (tape_we_d) begin
        tape_addr  <= tcnt_q;
        tape_wdata <= input_data[0];
        tcnt_q     <= (tcnt_q == TAPE_AW'(TAPE_LEN - 1)) ? '0 : tcnt_q + 1'b1;
      end

`ifdef TM_FREERUN_EN
      if (phase_q == RUN) begin
        if (halted)  free_q <= 1'b0;
        else if (dn) free_q <= ~free_q;
      end
`endif
    end
  end

  assign phase        = phase_q;
  assign Compute_done = (phase_q == HALT);

endmodule

// File: tb/tb_tm_program_sequencer.sv
// Directed self-checking bench for tm_program_sequencer (default parameters).
module tb_tm_program_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] input_data = '0;
  logic       Next = 1'b0;
  logic       Done = 1'b0;
  logic       halted = 1'b0;
  logic       rule_we;
  logic [4:0] rule_addr;
  logic [5:0] rule_wdata;
  logic       tape_we;
  logic [5:0] tape_addr;
  logic       tape_wdata;
  logic       step;
  logic [1:0] phase;
  logic       Compute_done;

  int errors = 0;
  int checks = 0;

  logic [4:0] rule_addr_obs[$];
  logic [5:0] rule_data_obs[$];
  logic [5:0] tape_addr_obs[$];
  logic       tape_data_obs[$];
  int         step_cnt = 0;

  tm_program_sequencer dut (
    .clock(clock), .reset(reset), .input_data(input_data), .Next(Next), .Done(Done),
    .halted(halted), .rule_we(rule_we), .rule_addr(rule_addr), .rule_wdata(rule_wdata),
    .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata), .step(step),
    .phase(phase), .Compute_done(Compute_done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (rule_we) begin rule_addr_obs.push_back(rule_addr); rule_data_obs.push_back(rule_wdata); end
    if (tape_we) begin tape_addr_obs.push_back(tape_addr); tape_data_obs.push_back(tape_wdata); end
    if (step) step_cnt++;
  end

  task automatic press_next(input logic [3:0] d, input int hold);
    @(posedge clock); #1; input_data = d; Next = 1'b1;
    repeat (hold) @(posedge clock);
    #1; Next = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic press_done();
    @(posedge clock); #1; Done = 1'b1;
    repeat (2) @(posedge clock);
    #1; Done = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic enter_rule(input logic [3:0] ns, input logic ws, input logic mr, input int hold);
    press_next(ns, hold);
    press_next({3'b000, ws}, hold);
    press_next({3'b000, mr}, hold);
  endtask

  task automatic clear_obs();
    rule_addr_obs.delete(); rule_data_obs.delete();
    tape_addr_obs.delete(); tape_data_obs.delete();
    step_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    if ({rule_we, tape_we, step, Compute_done} !== 4'b0) begin errors++;
      $display("FAIL reset_strobes: got %b, required 0000", {rule_we, tape_we, step, Compute_done}); end
    checks++;
    if ({rule_addr, rule_wdata, tape_addr, tape_wdata} !== '0) begin errors++;
      $display("FAIL reset_addr_data: got %h/%h/%h/%b, required all 0", rule_addr, rule_wdata, tape_addr, tape_wdata); end
    checks++;
    if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d, required 0", phase); end
    checks++;
    @(posedge clock); #1; reset = 1'b0;
    clear_obs();
  endtask

  task automatic test_rule_entry();
    enter_rule(4'd3, 1'b1, 1'b0, 6);
    if (rule_addr_obs.size() !== 1) begin errors++;
      $display("FAIL rule1_count: got %0d writes, required 1", rule_addr_obs.size()); end
    else if (rule_addr_obs[0] !== 5'd0 || rule_data_obs[0] !== 6'b0011_1_0) begin errors++;
      $display("FAIL rule1_write: got addr %0d data %b, required addr 0 data 001110", rule_addr_obs[0], rule_data_obs[0]); end
    checks++;
    enter_rule(4'd2, 1'b0, 1'b1, 6);
    if (rule_addr_obs.size() !== 2) begin errors++;
      $display("FAIL rule2_count: got %0d writes, required 2", rule_addr_obs.size()); end
    else if (rule_addr_obs[1] !== 5'd1 || rule_data_obs[1] !== 6'b0010_0_1) begin errors++;
      $display("FAIL rule2_write: got addr %0d data %b, required addr 1 data 001001", rule_addr_obs[1], rule_data_obs[1]); end
    checks++;
    if (rule_addr !== 5'd1 || rule_we !== 1'b0 || phase !== 2'd0) begin errors++;
      $display("FAIL rule_hold: got addr %0d we %b phase %0d, required addr 1 we 0 phase 0", rule_addr, rule_we, phase); end
    checks++;
  endtask

  task automatic test_rule_saturation();
    logic [5:0] exp_last;
    exp_last = '0;
    clear_obs();
    for (int i = 2; i < 32; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      enter_rule(iv[3:0], iv[0], ~iv[0], 2);
      exp_last = {iv[3:0], iv[0], ~iv[0]};
    end
    if (rule_addr_obs.size() !== 30) begin errors++;
      $display("FAIL sat_count: got %0d writes, required 30", rule_addr_obs.size()); end
    else if (rule_addr_obs[29] !== 5'd31 || rule_data_obs[29] !== exp_last) begin errors++;
      $display("FAIL sat_last: got addr %0d data %b, required addr 31 data %b", rule_addr_obs[29], rule_data_obs[29], exp_last); end
    checks++;
    enter_rule(4'd9, 1'b1, 1'b1, 2);
    if (rule_addr_obs.size() !== 30 || rule_addr !== 5'd31) begin errors++;
      $display("FAIL sat_suppress: got %0d writes addr %0d, required 30 writes addr 31", rule_addr_obs.size(), rule_addr); end
    checks++;
  endtask

  task automatic test_partial_rule();
    clear_obs();
    press_next(4'd1, 2);
    press_next(4'd1, 2);
    press_done();
    @(negedge clock);
    if (rule_addr_obs.size() !== 0) begin errors++;
      $display("FAIL partial_no_write: got %0d writes, required 0", rule_addr_obs.size()); end
    checks++;
    if (phase !== 2'd1) begin errors++; $display("FAIL partial_phase: got %0d, required 1", phase); end
    checks++;
  endtask

  task automatic test_tape_entry();
    logic [2:0] bits;
    bits = 3'b101;
    clear_obs();
    for (int i = 0; i < 3; i++) press_next({3'b000, bits[2-i]}, 1);
    for (int i = 0; i < 3; i++) begin
      if (tape_addr_obs.size() <= i) begin errors++;
        $display("FAIL tape_write%0d: got no write, required addr %0d", i, i); end
      else if (tape_addr_obs[i] !== 6'(i) || tape_data_obs[i] !== bits[2-i]) begin errors++;
        $display("FAIL tape_write%0d: got addr %0d data %b, required addr %0d data %b", i, tape_addr_obs[i], tape_data_obs[i], i, bits[2-i]); end
      checks++;
    end
    for (int i = 3; i < 64; i++) press_next({3'b000, 1'(i)}, 1);
    press_next(4'd1, 1);
    if (tape_addr_obs.size() !== 65) begin errors++;
      $display("FAIL tape_wrap_count: got %0d writes, required 65", tape_addr_obs.size()); end
    else if (tape_addr_obs[63] !== 6'd63 || tape_addr_obs[64] !== 6'd0 || tape_data_obs[64] !== 1'b1) begin errors++;
      $display("FAIL tape_wrap: got addr %0d then %0d data %b, required 63 then 0 data 1", tape_addr_obs[63], tape_addr_obs[64], tape_data_obs[64]); end
    checks++;
  endtask

  task automatic test_simultaneous();
    clear_obs();
    @(posedge clock); #1; input_data = 4'd1; Next = 1'b1; Done = 1'b1;
    repeat (3) @(posedge clock);
    #1; Next = 1'b0; Done = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    if (tape_addr_obs.size() !== 0 || phase !== 2'd2) begin errors++;
      $display("FAIL simultaneous: got %0d tape writes phase %0d, required 0 writes phase 2", tape_addr_obs.size(), phase); end
    checks++;
  endtask

  task automatic test_run();
    clear_obs();
    for (int i = 0; i < 3; i++) press_next(4'd0, 3);
    if (step_cnt !== 3) begin errors++; $display("FAIL run_steps: got %0d steps, required 3", step_cnt); end
    checks++;
`ifdef TM_FREERUN_EN
    press_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (step !== 1'b1) begin errors++; $display("FAIL freerun_step%0d: got %b, required 1", i, step); end
      checks++;
    end
`else
    step_cnt = 0;
    press_done();
    @(negedge clock);
    if (step_cnt !== 0 || phase !== 2'd2) begin errors++;
      $display("FAIL run_done_ignored: got %0d steps phase %0d, required 0 steps phase 2", step_cnt, phase); end
    checks++;
`endif
    // Halt and a Next edge land in the same cycle: the step is dropped.
    @(posedge clock); #1; halted = 1'b1; Next = 1'b1;
    @(negedge clock);
    step_cnt = 0;
    @(posedge clock); #1; halted = 1'b0;
    @(negedge clock);
    if (phase !== 2'd3 || Compute_done !== 1'b1) begin errors++;
      $display("FAIL halt_entry: got phase %0d done %b, required phase 3 done 1", phase, Compute_done); end
    checks++;
    @(posedge clock); #1; Next = 1'b0;
    press_next(4'd0, 2);
    press_done();
    @(negedge clock);
    if (step_cnt !== 0 || phase !== 2'd3) begin errors++;
      $display("FAIL halt_ignore: got %0d steps phase %0d, required 0 steps phase 3", step_cnt, phase); end
    checks++;
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    if (phase !== 2'd0 || Compute_done !== 1'b0) begin errors++;
      $display("FAIL halt_reset: got phase %0d done %b, required phase 0 done 0", phase, Compute_done); end
    checks++;
  endtask

  task automatic test_reset_midphase();
    clear_obs();
    press_next(4'd7, 2);
    press_next(4'd1, 2);
    @(posedge clock); #1; input_data = 4'd1; Next = 1'b1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0; Next = 1'b0;
    repeat (2) @(posedge clock);
    if (rule_addr_obs.size() !== 0) begin errors++;
      $display("FAIL midreset_no_write: got %0d writes, required 0", rule_addr_obs.size()); end
    checks++;
    enter_rule(4'd4, 1'b0, 1'b1, 2);
    if (rule_addr_obs.size() !== 1) begin errors++;
      $display("FAIL midreset_restart_count: got %0d writes, required 1", rule_addr_obs.size()); end
    else if (rule_addr_obs[0] !== 5'd0 || rule_data_obs[0] !== 6'b0100_0_1) begin errors++;
      $display("FAIL midreset_restart: got addr %0d data %b, required addr 0 data 010001", rule_addr_obs[0], rule_data_obs[0]); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_rule_entry();
    test_rule_saturation();
    test_partial_rule();
    test_tape_entry();
    test_simultaneous();
    test_run();
    test_reset_midphase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm_program_sequencer.md
# tm_program_sequencer

Front-panel controller for the Turing machine datapath. It turns the 4-bit `input_data` nibble and the `Next`/`Done` buttons into three things: rule-table writes, initial-tape writes, and single-step pulses. It sits between the pad inputs and the TuringMachine rule memory, tape register and state register. It owns the LOAD_RULE → LOAD_TAPE → RUN → HALT phase sequence.

## Interface
Parameters:
- `STATE_W`, default 4: state-index width; must be ≤ 4.
- `TAPE_LEN`, default 64: number of tape cells; `TAPE_AW = $clog2(TAPE_LEN)`.

Ports:
- `clock`  in  1: sole clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high; clears every register.
- `input_data`  in  4: user nibble.
- `Next`  in  1: level button; only rising edges are acted on.
- `Done`  in  1: level button; only rising edges are acted on.
- `halted`  in  1: datapath has entered its halt state.
- `rule_we`  out  1: one-cycle rule write strobe.
- `rule_addr`  out  STATE_W+1: `{state, read_symbol}` index.
- `rule_wdata`  out  STATE_W+2: `{next_state, write_sym, move_right}`.
- `tape_we`  out  1: one-cycle tape write strobe.
- `tape_addr`  out  TAPE_AW: tape cell index.
- `tape_wdata`  out  1: tape bit.
- `step`  out  1: one-cycle datapath advance pulse.
- `phase`  out  2: 0 LOAD_RULE, 1 LOAD_TAPE, 2 RUN, 3 HALT.
- `Compute_done`  out  1: high in HALT.

## Operation
Edge detection:
- `nx_e = Next & ~next_q` and `dn_e = Done & ~done_q`, where `next_q` and `done_q` are the previous-cycle samples.
- Holding a button produces exactly one event.
- If `dn_e` and `nx_e` occur in the same cycle, `dn_e` wins and `nx_e` is dropped.

LOAD_RULE:
- A 2-bit field counter `fld` cycles 0→1→2.
- On `nx_e`:
  - `fld=0`: latch `input_data[STATE_W-1:0]` as next_state.
  - `fld=1`: latch `input_data[0]` as write_sym.
  - `fld=2`: latch `input_data[0]` as move_right, then write the rule.
- Each rule write increments the rule counter `rcnt` (STATE_W+1 bits); `rule_addr = rcnt` as it was before the increment.
- `rcnt` saturates at all-ones. Once it is saturated and that entry has been written, further writes are suppressed (`rule_we` stays 0).
- On `dn_e`: discard any partial field, go to LOAD_TAPE, clear `fld`.

LOAD_TAPE:
- On `nx_e`: `tape_we`, `tape_wdata = input_data[0]`, `tape_addr = tcnt`, then `tcnt` increments.
- `tcnt` wraps from TAPE_LEN-1 to 0, overwriting cell 0.
- On `dn_e`: go to RUN.

RUN:
- Each `nx_e` issues one `step` pulse.
- `halted=1` sampled in RUN moves to HALT; a step event arriving in that same cycle is dropped.

HALT:
- `Compute_done=1`.
- `nx_e` and `dn_e` are ignored; only `reset` leaves HALT.

Reset mid-phase: returns to LOAD_RULE with all counters, field latches and strobes cleared. No partial write is emitted.

Reset values: every output is 0 (`phase=0`, `Compute_done=0`, all strobes/addresses/data 0).

## Timing
- All outputs are registered.
- Edge at posedge k (`Next` sampled 1, `next_q` 0) → strobe (`rule_we`, `tape_we` or `step`) high during cycle k+1, for exactly one cycle.
- Address and data are valid in the same cycle as the strobe and hold until the next strobe.
- `phase` changes at posedge k+1 after a `dn_e` at k.
- `Compute_done` rises in the cycle after `halted` is sampled.
- Minimum event spacing: one edge per 2 cycles, since the button must be seen low for at least one sample between presses.

## Configuration
`TM_FREERUN_EN`, when defined:
- In RUN, `dn_e` toggles a free-run flag.
- While the flag is set, `step` pulses every cycle until `halted`.
- Another `dn_e` clears the flag and returns to single-step.
- `nx_e` is ignored while free-running.

When undefined:
- `dn_e` in RUN is ignored.
- No free-run flag register exists.

## Structure
- Shared package `tm_pkg`:
  - `phase_t` enum with encodings LOAD_RULE=0, LOAD_TAPE=1, RUN=2, HALT=3.
  - `rule_t` packed struct `{next_state, write_sym, move_right}`.
  - Defaults for `STATE_W` and `TAPE_LEN`.
- One sub-module, `tm_btn_edge`: a registered rising-edge detector, instantiated for `Next` and for `Done`.
- The FSM and counters live in the top module.

## Test plan
- Reset is held for 2 cycles: all outputs are 0 and `phase=0`.
- Rule entry: nibbles 3, 1, 0 are entered, each with `Next` held for 6 cycles. Required response: a single `rule_we` pulse with `rule_addr=0` and `rule_wdata=6'b0011_1_0`. A second rule 2, 0, 1 gives addr 1 and data `0010_0_1`.
- A partial rule (nibbles 1 and 1 only) followed by `Done`: no `rule_we`, `phase=1`. A subsequent rule entry restarts at `fld=0`.
- Tape entry: bits 1, 0, 1 are entered. Required response: `tape_we` at addr 0, 1, 2 with data 1, 0, 1. After 64 entries the next write lands at addr 0.
- RUN: 3 `Next` presses → exactly 3 `step` pulses. `halted` asserted → `phase=3` and `Compute_done=1` the next cycle. Further `Next` presses → no `step`. `reset` → `phase=0`.
- Simultaneous edges: `Next` and `Done` rise on the same cycle in LOAD_TAPE. Required response: no `tape_we`, `phase=2`.
- With `TM_FREERUN_EN` defined: `Done` in RUN → `step` high on every cycle until `halted`.
